spi_ram_ctrl: RTL and testbench
===============================

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: RAM address width.
REQ-002 Parameter STARVE_LIM, default 4: consecutive host denials before the host is forced a grant.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  10  SPI slave frame: [9:8] command, [7:0] payload.
REQ-006 rx_valid  input  1  one-cycle pulse qualifying rx_data.
REQ-007 tx_data  output  8  read data returned to the SPI slave.
REQ-008 tx_valid  output  1  tx_data valid (level).
REQ-009 ram_addr  output  ADDR_W  single-port RAM address.
REQ-010 ram_din  output  8  RAM write data.
REQ-011 ram_we / ram_re  output  1 each  RAM write / read strobes; never both high.
REQ-012 ram_dout  input  8  RAM read data, valid exactly 1 cycle after ram_re.
REQ-013 host_req, host_we  input  1 each  host access request (level) and write-not-read.
REQ-014 host_addr  input  ADDR_W;  host_wdata  input  8.
REQ-015 host_gnt  output  1  one-cycle pulse: host access issued this cycle.
REQ-016 host_rvalid  output  1;  host_rdata  output  8  host read return.
REQ-017 err_ovf  output  1  sticky: SPI pending operation overwritten.

Function
REQ-018 Command decode on rx_valid: 00 = load wr_ptr; 01 = write data; 10 = load rd_ptr; 11 = read request.
REQ-019 Cmd 00/10 loads wr_ptr/rd_ptr from rx_data[ADDR_W-1:0] in the same cycle; no RAM access.
REQ-020 Cmd 01 captures {wr_ptr, rx_data[7:0]} into a single-entry SPI pending buffer as a write, then wr_ptr+1 (wraps max->0).
REQ-021 Cmd 11 captures rd_ptr into the pending buffer as a read, then rd_ptr+1 (wraps max->0).
REQ-022 Any rx_valid drives tx_valid low on the next cycle.
REQ-023 Cmd 01/11 arriving while the pending buffer is full: new entry overwrites, err_ovf set.
REQ-024 Cmd 01/11 arriving in the cycle the old entry is issued: old entry issued, new entry captured, no error.
REQ-025 Arbiter FSM states IDLE, SPI_ACC, HOST_ACC; each ACC state lasts exactly one cycle, one RAM access per cycle.
REQ-026 Next state: SPI_ACC if pending valid and starve_cnt < STARVE_LIM; HOST_ACC if host_req and (no pending or starve_cnt = STARVE_LIM); else IDLE.
REQ-027 Back-to-back ACC cycles allowed; no idle cycle is inserted between accesses.
REQ-028 starve_cnt increments each cycle host_req is high and not granted, saturates at STARVE_LIM, clears on host grant or host_req low.
REQ-029 SPI_ACC: ram_addr/ram_din from the pending entry, ram_we or ram_re per type, pending cleared.
REQ-030 HOST_ACC: ram_addr = host_addr, ram_we = host_we, ram_re = !host_we, ram_din = host_wdata, host_gnt = 1.
REQ-031 SPI read issued in cycle N: at N+1 tx_data <= ram_dout; tx_valid high from N+2 until next rx_valid.
REQ-032 Host read granted in cycle N: at N+1 host_rdata <= ram_dout; host_rvalid pulses for one cycle at N+2.
REQ-033 Pending SPI read is not issued before a prior SPI read has returned (ordering preserved).

Reset
REQ-034 rst_n low at a clock edge: FSM to IDLE; pending buffer, wr_ptr, rd_ptr, starve_cnt cleared.
REQ-035 During reset: all outputs 0 (ram_we, ram_re, host_gnt, tx_valid, host_rvalid, err_ovf, tx_data, host_rdata, ram_addr, ram_din).
REQ-036 Reset mid-operation: an in-flight read return is discarded; no ram_we in the cycle following reset release.

Verification
REQ-037 SPI 0x000, 0x1AA, 0x155 -> RAM[0]=0xAA, RAM[1]=0x55; wr_ptr=2.
REQ-038 SPI 0x200, 0x3xx with RAM[0]=0xAA -> tx_data=0xAA; tx_valid rises 2 cycles after ram_re; rd_ptr=1.
REQ-039 wr_ptr=0xFF, cmd 0x1 write 0x11 then 0x22 -> RAM[0xFF]=0x11, RAM[0x00]=0x22 (wrap).
REQ-040 host_req held while SPI writes are pending every cycle -> host_gnt within STARVE_LIM+1 cycles; SPI traffic resumes after grant.
REQ-041 Two cmd 01 frames with no intervening issue (host forced grant) -> err_ovf=1; only second data written.
REQ-042 rst_n low one cycle after SPI read issue -> tx_valid stays 0, host_rvalid stays 0, all strobes 0.

Source files
------------

// File: rtl/spi_ram_ctrl_if.sv
// Signal bundle for spi_ram_ctrl: SPI frame port, single-port RAM port
// and host access port.
interface spi_ram_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [9:0]        rx_data;
   logic              rx_valid;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_din;
   logic              ram_we;
   logic              ram_re;
   logic [7:0]        ram_dout;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [7:0]        host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [7:0]        host_rdata;
   logic              err_ovf;

   modport slave (
      input  rx_data, rx_valid, ram_dout,
      input  host_req, host_we, host_addr, host_wdata,
      output tx_data, tx_valid, ram_addr, ram_din,
      output ram_we, ram_re, host_gnt, host_rvalid,
      output host_rdata, err_ovf
   );

   modport master (
      output rx_data, rx_valid, ram_dout,
      output host_req, host_we, host_addr, host_wdata,
      input  tx_data, tx_valid, ram_addr, ram_din,
      input  ram_we, ram_re, host_gnt, host_rvalid,
      input  host_rdata, err_ovf
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Arbitrates a single-port RAM between an SPI command stream (one pending
// entry) and a host port, with starvation protection for the host.
module spi_ram_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int STARVE_LIM = 4
) (
   input logic           clk,
   input logic           rst_n,
   spi_ram_ctrl_if.slave bus
);

   localparam int CW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

   typedef enum logic [1:0] {
      IDLE,
      SPI_ACC,
      HOST_ACC
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic              pend_v_q, pend_v_d;
   logic              pend_rd_q;
   logic [ADDR_W-1:0] pend_addr_q;
   logic [7:0]        pend_data_q;
   logic [CW-1:0]     starve_q, starve_d;
   logic              spi_rd_q, spi_ret_q;
   logic              host_rd_q, host_ret_q;
   logic [7:0]        tx_data_q, host_rdata_q, ram_din_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              tx_valid_q, host_rvalid_q;
   logic              ram_we_q, ram_re_q, host_gnt_q, err_ovf_q;

   logic [1:0] cmd;
   logic       cap, pend_ok, starved;
   logic       sel_spi, sel_host, ovf;

   assign cmd = bus.rx_data[9:8];
   assign cap = bus.rx_valid & cmd[0];

   // A queued read waits until the previous SPI read has returned.
   assign pend_ok  = pend_v_q & ~(pend_rd_q & (spi_rd_q | spi_ret_q));
   assign starved  = (starve_q == LIM);
   assign sel_spi  = pend_ok & ~starved;
   assign sel_host = bus.host_req & (~pend_ok | starved);
   assign ovf      = cap & pend_v_q & ~sel_spi;

   always_comb begin
      state_d  = IDLE;
      starve_d = starve_q;
      pend_v_d = cap | (pend_v_q & ~sel_spi);
      if (sel_spi)
         state_d = SPI_ACC;
      else if (sel_host)
         state_d = HOST_ACC;
      if (!bus.host_req || sel_host)
         starve_d = '0;
      else if (!starved)
         starve_d = starve_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         pend_v_q      <= 1'b0;
         pend_rd_q     <= 1'b0;
         pend_addr_q   <= '0;
         pend_data_q   <= '0;
         starve_q      <= '0;
         spi_rd_q      <= 1'b0;
         spi_ret_q     <= 1'b0;
         host_rd_q     <= 1'b0;
         host_ret_q    <= 1'b0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         ram_addr_q    <= '0;
         ram_din_q     <= '0;
         ram_we_q      <= 1'b0;
         ram_re_q      <= 1'b0;
         host_gnt_q    <= 1'b0;
         err_ovf_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         host_gnt_q <= 1'b0;
         spi_rd_q   <= 1'b0;
         host_rd_q  <= 1'b0;

         unique case (1'b1)
            sel_spi: begin
               ram_addr_q <= pend_addr_q;
               ram_din_q  <= pend_data_q;
               ram_we_q   <= ~pend_rd_q;
               ram_re_q   <= pend_rd_q;
               spi_rd_q   <= pend_rd_q;
            end
            sel_host: begin
               ram_addr_q <= bus.host_addr;
               ram_din_q  <= bus.host_wdata;
               ram_we_q   <= bus.host_we;
               ram_re_q   <= ~bus.host_we;
               host_rd_q  <= ~bus.host_we;
               host_gnt_q <= 1'b1;
            end
            default: ;
         endcase

         pend_v_q <= pend_v_d;
         if (cap) begin
            pend_rd_q   <= cmd[1];
            pend_addr_q <= cmd[1] ? rd_ptr_q : wr_ptr_q;
            pend_data_q <= bus.rx_data[7:0];
         end
         if (ovf)
            err_ovf_q <= 1'b1;

         if (bus.rx_valid) begin
            unique case (cmd)
               2'b00: wr_ptr_q <= bus.rx_data[ADDR_W-1:0];
               2'b01: wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
               2'b10: rd_ptr_q <= bus.rx_data[ADDR_W-1:0];
               2'b11: rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            endcase
         end

         // RAM data is valid the cycle after the strobe.
         spi_ret_q  <= spi_rd_q;
         host_ret_q <= host_rd_q;
         if (spi_ret_q)
            tx_data_q <= bus.ram_dout;
         if (bus.rx_valid)
            tx_valid_q <= 1'b0;
         else if (spi_ret_q)
            tx_valid_q <= 1'b1;
         if (host_ret_q)
            host_rdata_q <= bus.ram_dout;
         host_rvalid_q <= host_ret_q;
      end
   end

   assign bus.tx_data     = tx_data_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_din     = ram_din_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_re      = ram_re_q;
   assign bus.host_gnt    = host_gnt_q;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_rdata  = host_rdata_q;
   assign bus.err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed and randomized bench for spi_ram_ctrl with a behavioural RAM
// and an address-level reference memory.
module tb_spi_ram_ctrl;
   localparam int AW  = 8;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_ram_ctrl_if #(.ADDR_W(AW)) bus ();

   spi_ram_ctrl #(.ADDR_W(AW), .STARVE_LIM(LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];

   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr];
   end

   int vec = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [9:0] f);
      bus.rx_data  = f;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_for(input int which, input int lim, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < lim && !ok; k++) begin
         case (which)
            0:       ok = bus.ram_re;
            1:       ok = bus.tx_valid;
            default: ok = bus.host_gnt;
         endcase
         if (!ok) tick();
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      tick();
      tick();
      chk({tag, "_strobes"}, 32'({bus.ram_we, bus.ram_re, bus.host_gnt,
          bus.tx_valid, bus.host_rvalid, bus.err_ovf}), 32'h0);
      chk({tag, "_data"}, {bus.tx_data, bus.host_rdata, bus.ram_din,
          bus.ram_addr}, 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      bit ok;
      int gnt_at, lost, good;
      logic [7:0] wr_m, rd_m, h_addr, h_wdata, d;
      logic h_we;
      logic [7:0] q_tx [$];
      bit prev_tx, after_rx;
      int gap, hwait, hidle, rv_due, r;

      foreach (mem[i]) mem[i] = 8'h00;
      bus.rx_data    = '0;
      bus.rx_valid   = 1'b0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;

      do_reset("reset");
      tick();

      // Writes with pointer load
      send(10'h000);
      send(10'h1AA);
      send(10'h155);
      idle(6);
      chk("wr_ram0", 32'(mem[0]), 32'hAA);
      chk("wr_ram1", 32'(mem[1]), 32'h55);
      send(10'h177);
      idle(6);
      chk("wr_ptr2", 32'(mem[2]), 32'h77);
      chk("no_ovf", 32'(bus.err_ovf), 32'h0);

      // Read path latency
      send(10'h200);
      send(10'h300);
      wait_for(0, 10, ok);
      chk("rd_issue", 32'(ok), 32'h1);
      tick();
      chk("rd_tx_n1", 32'(bus.tx_valid), 32'h0);
      tick();
      chk("rd_tx_n2", 32'(bus.tx_valid), 32'h1);
      chk("rd_data0", 32'(bus.tx_data), 32'hAA);
      send(10'h300);
      chk("rd_drop", 32'(bus.tx_valid), 32'h0);
      wait_for(1, 12, ok);
      chk("rd_seen1", 32'(ok), 32'h1);
      chk("rd_data1", 32'(bus.tx_data), 32'h55);

      // Write pointer wrap
      send(10'h0FF);
      send(10'h111);
      send(10'h122);
      idle(6);
      chk("wrap_ff", 32'(mem[8'hFF]), 32'h11);
      chk("wrap_00", 32'(mem[8'h00]), 32'h22);

      // Host starvation limit and pending overwrite
      do_reset("reset2");
      send(10'h020);
      gnt_at = -1;
      for (int i = 0; i < 8; i++) begin
         if (bus.host_req && bus.host_gnt) begin
            gnt_at = i;
            bus.host_req = 1'b0;
         end
         if (i == 1) begin
            bus.host_req   = 1'b1;
            bus.host_we    = 1'b1;
            bus.host_addr  = 8'h90;
            bus.host_wdata = 8'h5A;
         end
         bus.rx_data  = {2'b01, 8'(8'h30 + i)};
         bus.rx_valid = 1'b1;
         tick();
      end
      bus.rx_valid = 1'b0;
      if (gnt_at < 0 && bus.host_req) begin
         wait_for(2, 8, ok);
         bus.host_req = 1'b0;
      end
      idle(8);
      chk("gnt_lat", 32'(gnt_at >= 0 && gnt_at - 1 <= LIM + 1), 32'h1);
      chk("host_wr", 32'(mem[8'h90]), 32'h5A);
      chk("ovf_flag", 32'(bus.err_ovf), 32'h1);
      lost = 0;
      good = 0;
      for (int j = 0; j < 8; j++) begin
         if (mem[8'h20 + j] == 8'h00) lost++;
         else if (mem[8'h20 + j] == 8'(8'h30 + j)) good++;
      end
      chk("ovf_lost", 32'(lost), 32'h1);
      chk("ovf_kept", 32'(good), 32'h7);
      chk("spi_resume", 32'(mem[8'h27]), 32'h37);

      // Reset with an SPI read in flight
      send(10'h200);
      send(10'h300);
      wait_for(0, 10, ok);
      chk("rst_rd_issue", 32'(ok), 32'h1);
      tick();
      rst_n = 1'b0;
      tick();
      chk("rst_mid", 32'({bus.ram_we, bus.ram_re, bus.tx_valid,
          bus.host_rvalid, bus.err_ovf}), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("rst_quiet", 32'({bus.ram_we, bus.ram_re, bus.host_gnt,
             bus.tx_valid, bus.host_rvalid}), 32'h0);
         tick();
      end

      // Randomized traffic: SPI in 0x00-0x7F, host in 0x80-0xFF
      foreach (mem[i]) ref_mem[i] = mem[i];
      wr_m = 8'($urandom_range(0, 63));
      rd_m = 8'($urandom_range(0, 63));
      send({2'b00, wr_m});
      send({2'b10, rd_m});
      prev_tx  = bus.tx_valid;
      after_rx = 1'b0;
      gap = 2;
      hwait = 0;
      hidle = 0;
      rv_due = -1;
      h_addr = '0;
      h_we = 1'b0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         chk("we_re_excl", 32'(bus.ram_we & bus.ram_re), 32'h0);
         if (bus.tx_valid && !prev_tx) begin
            if (q_tx.size() == 0) chk("tx_unexp", 32'h1, 32'h0);
            else chk("tx_data", 32'(bus.tx_data), 32'(q_tx.pop_front()));
         end
         prev_tx = bus.tx_valid;
         if (after_rx) chk("tx_drop", 32'(bus.tx_valid), 32'h0);
         after_rx = 1'b0;
         chk("rvalid", 32'(bus.host_rvalid), 32'(cyc == rv_due));
         if (cyc == rv_due)
            chk("host_rdata", 32'(bus.host_rdata), 32'(ref_mem[h_addr]));
         if (!bus.host_req)
            chk("gnt_spur", 32'(bus.host_gnt), 32'h0);

         if (bus.host_req) begin
            if (bus.host_gnt) begin
               bus.host_req = 1'b0;
               if (h_we) ref_mem[h_addr] = h_wdata;
               else rv_due = cyc + 2;
               hidle = $urandom_range(0, 4);
            end else begin
               hwait++;
               if (hwait > LIM + 2) begin
                  chk("gnt_timeout", 32'h0, 32'h1);
                  bus.host_req = 1'b0;
               end
            end
         end else if (hidle > 0) begin
            hidle--;
         end else if (cyc < 400 && rv_due < cyc
                      && $urandom_range(0, 2) == 0) begin
            h_we    = 1'($urandom_range(0, 1));
            h_addr  = 8'(8'h80 | $urandom_range(0, 127));
            h_wdata = 8'($urandom_range(0, 255));
            bus.host_req   = 1'b1;
            bus.host_we    = h_we;
            bus.host_addr  = h_addr;
            bus.host_wdata = h_wdata;
            hwait = 0;
         end

         bus.rx_valid = 1'b0;
         if (gap > 0) begin
            gap--;
         end else if (cyc < 400) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom_range(0, 255));
            if (wr_m >= 8'h78 || r == 0) begin
               wr_m = 8'($urandom_range(0, 63));
               bus.rx_data = {2'b00, wr_m};
            end else if (rd_m >= 8'h78 || r == 1) begin
               rd_m = 8'($urandom_range(0, 63));
               bus.rx_data = {2'b10, rd_m};
            end else if (r < 6) begin
               ref_mem[wr_m] = d;
               wr_m = wr_m + 8'd1;
               bus.rx_data = {2'b01, d};
            end else begin
               q_tx.push_back(ref_mem[rd_m]);
               rd_m = rd_m + 8'd1;
               bus.rx_data = {2'b11, d};
            end
            bus.rx_valid = 1'b1;
            after_rx = 1'b1;
            gap = $urandom_range(7, 10);
         end
         tick();
      end
      bus.rx_valid = 1'b0;
      bus.host_req = 1'b0;
      chk("tx_drained", 32'(q_tx.size()), 32'h0);
      for (int a = 0; a < 256; a++)
         chk("ram_final", 32'(mem[a]), 32'(ref_mem[a]));

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
